// File: rtl/fb_pkg.sv
// Shared constants and FSM encoding for the framebuffer draw path.
package fb_pkg;
  localparam int FB_WIDTH_DEF  = 800;
  localparam int FB_HEIGHT_DEF = 600;
  localparam int COORD_W       = 11;
  localparam int GAP_CYCLES    = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_GAP
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: highest priority is the index after the last grant.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW-1:0] ptr;
  logic          found;

  // Scan requests starting at the pointer; first hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    any   = |req;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + i) % N_REQ);
      end
    end
    gnt = '0;
    for (int i = 0; i < N_REQ; i++)
      gnt[i] = en && any && (idx == IW'(i));
  end

  // Pointer moves past the winner only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (en && any)
      ptr <= (int'(idx) == N_REQ - 1) ? '0 : idx + IW'(1);
  end
endmodule

// File: rtl/blit_scheduler.sv
// Draw-command scheduler: arbitrates rectangle commands, streams the
// winner's pixels to the burst writer with per-beat coordinates, and owns
// front/back buffer selection (swaps only between commands).
module blit_scheduler
  import fb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int FB_WIDTH  = FB_WIDTH_DEF,
  parameter  int FB_HEIGHT = FB_HEIGHT_DEF,
  localparam int IW        = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              fb_base0,
  input  logic [31:0]              fb_base1,
  input  logic                     swap_req,
  output logic                     front_sel,
  output logic                     swap_ack,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*COORD_W-1:0] req_x,
  input  logic [N_REQ*COORD_W-1:0] req_y,
  input  logic [N_REQ*COORD_W-1:0] req_w,
  input  logic [N_REQ*COORD_W-1:0] req_h,
  input  logic [N_REQ*8-1:0]       src_data,
  input  logic [N_REQ-1:0]         src_draw,
  input  logic [N_REQ-1:0]         src_valid,
  output logic [N_REQ-1:0]         src_ready,
  output logic [31:0]              wr_baseaddr,
  output logic [COORD_W-1:0]       wr_pixel_x,
  output logic [COORD_W-1:0]       wr_pixel_y,
  output logic [COORD_W-1:0]       wr_width,
  output logic [COORD_W-1:0]       wr_height,
  output logic [7:0]               wr_pixel_data,
  output logic                     wr_pixel_valid,
  output logic                     wr_draw,
  input  logic                     wr_pixel_ready,
  input  logic                     wr_bvalid,
  output logic                     busy,
  output logic [IW-1:0]            grant_id,
  output logic                     done
);
  state_t             state, state_n;
  logic [COORD_W-1:0] x0, col, row;
  logic [COORD_W:0]   cur_x, cur_y;   // one extra bit so off-screen never wraps
  logic [1:0]         gap_cnt;
  logic               pend;
  logic               apply_swap, beat, last_beat;
  logic               arb_en, arb_any;
  logic [N_REQ-1:0]   arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               in_fb;
  int                 sel, asel;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .en    (arb_en),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign sel        = int'(grant_id);
  assign asel       = int'(arb_idx);
  assign in_fb      = (cur_x < (COORD_W+1)'(FB_WIDTH)) && (cur_y < (COORD_W+1)'(FB_HEIGHT));
  assign wr_pixel_x = cur_x[COORD_W-1:0];
  assign wr_pixel_y = cur_y[COORD_W-1:0];
  assign busy       = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and combinational handshakes; a pending swap beats a grant.
  always_comb begin
    state_n        = state;
    apply_swap     = 1'b0;
    arb_en         = 1'b0;
    req_ready      = '0;
    src_ready      = '0;
    wr_pixel_valid = 1'b0;
    wr_pixel_data  = '0;
    wr_draw        = 1'b0;
    beat           = 1'b0;
    last_beat      = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend) begin
          apply_swap = 1'b1;
        end else if (arb_any) begin
          arb_en    = 1'b1;
          req_ready = arb_gnt;
          state_n   = S_STREAM;
        end
      end
      S_STREAM: begin
        wr_pixel_valid = src_valid[sel];
        src_ready[sel] = wr_pixel_ready;
        wr_pixel_data  = src_data[sel*8 +: 8];
        wr_draw        = src_draw[sel] && in_fb;
        beat           = src_valid[sel] && wr_pixel_ready;
        last_beat      = beat && (col == wr_width) && (row == wr_height);
        if (last_beat) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_bvalid) state_n = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == 2'(GAP_CYCLES - 1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Command latch, raster walk, swap bookkeeping and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      x0          <= '0;
      col         <= '0;
      row         <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      gap_cnt     <= '0;
      pend        <= 1'b0;
      front_sel   <= 1'b0;
      swap_ack    <= 1'b0;
      done        <= 1'b0;
      grant_id    <= '0;
      wr_baseaddr <= '0;
      wr_width    <= '0;
      wr_height   <= '0;
    end else begin
      done     <= (state == S_DRAIN) && wr_bvalid;
      swap_ack <= apply_swap;
      pend     <= (pend && !apply_swap) || swap_req;
      gap_cnt  <= (state == S_GAP) ? gap_cnt + 2'd1 : 2'd0;
      if (apply_swap) front_sel <= !front_sel;
      if (arb_en) begin
        // Drawing always targets the back buffer.
        grant_id    <= arb_idx;
        wr_baseaddr <= front_sel ? fb_base0 : fb_base1;
        x0          <= req_x[asel*COORD_W +: COORD_W];
        cur_x       <= {1'b0, req_x[asel*COORD_W +: COORD_W]};
        cur_y       <= {1'b0, req_y[asel*COORD_W +: COORD_W]};
        wr_width    <= req_w[asel*COORD_W +: COORD_W];
        wr_height   <= req_h[asel*COORD_W +: COORD_W];
        col         <= '0;
        row         <= '0;
      end else if (beat) begin
        if (col == wr_width) begin
          col   <= '0;
          cur_x <= {1'b0, x0};
          row   <= row + 1'b1;
          cur_y <= cur_y + 1'b1;
        end else begin
          col   <= col + 1'b1;
          cur_x <= cur_x + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_blit_scheduler.sv
// Directed bench for blit_scheduler with a raster-level reference model.
module tb_blit_scheduler;
  localparam int N = 4;
  localparam logic [31:0] B0 = 32'hA000_0000;
  localparam logic [31:0] B1 = 32'hB000_0000;

  logic          clk, reset;
  logic [31:0]   fb_base0, fb_base1;
  logic          swap_req, front_sel, swap_ack;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*11-1:0] req_x, req_y, req_w, req_h;
  logic [N*8-1:0] src_data;
  logic [N-1:0]  src_draw, src_valid, src_ready;
  logic [31:0]   wr_baseaddr;
  logic [10:0]   wr_pixel_x, wr_pixel_y, wr_width, wr_height;
  logic [7:0]    wr_pixel_data;
  logic          wr_pixel_valid, wr_draw, wr_pixel_ready, wr_bvalid;
  logic          busy, done;
  logic [1:0]    grant_id;

  blit_scheduler #(.N_REQ(N), .FB_WIDTH(800), .FB_HEIGHT(600)) dut (
    .clk(clk), .reset(reset), .fb_base0(fb_base0), .fb_base1(fb_base1),
    .swap_req(swap_req), .front_sel(front_sel), .swap_ack(swap_ack),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .src_data(src_data), .src_draw(src_draw), .src_valid(src_valid), .src_ready(src_ready),
    .wr_baseaddr(wr_baseaddr), .wr_pixel_x(wr_pixel_x), .wr_pixel_y(wr_pixel_y),
    .wr_width(wr_width), .wr_height(wr_height), .wr_pixel_data(wr_pixel_data),
    .wr_pixel_valid(wr_pixel_valid), .wr_draw(wr_draw), .wr_pixel_ready(wr_pixel_ready),
    .wr_bvalid(wr_bvalid), .busy(busy), .grant_id(grant_id), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] x, y;
    logic        draw;
    logic [31:0] base;
  } beat_t;

  int checks = 0, fails = 0;
  int n_beats = 0, n_draws = 0, n_done = 0, n_ack = 0;
  int swaps_issued = 0;
  int grants[$];
  beat_t q[$];
  logic last_pulse = 1'b0;
  int src_cnt[N];
  int bv_delay = 0;
  logic stall_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expands each grant into its raster of beats and checks
  // every writer-side cycle against it.
  initial begin : model
    int active, cur_g, front_m, swaps_seen, g, x0, y0, w, h;
    int model_cnt[N];
    logic exp_done_n;
    beat_t b;
    active = 0; cur_g = 0; front_m = 0; swaps_seen = 0; exp_done_n = 1'b0;
    for (int i = 0; i < N; i++) model_cnt[i] = 0;
    forever begin
      @(negedge clk);
      last_pulse = 1'b0;
      if (reset) begin
        if (active != 0 && wr_pixel_valid && wr_pixel_ready) model_cnt[cur_g]++;
        q.delete();
        active = 0; exp_done_n = 1'b0; front_m = 0; swaps_seen = swaps_issued;
      end else begin
        chk("done_pulse", {31'd0, done}, {31'd0, exp_done_n});
        if (done) begin n_done++; active = 0; end
        if (exp_done_n) begin
          chk("gap_quiet_done", {27'd0, req_ready, wr_pixel_valid}, 32'd0);
        end
        if (swap_ack) n_ack++;
        chk("pix_valid", {31'd0, wr_pixel_valid},
            {31'd0, (active != 0) && (q.size() > 0) && src_valid[cur_g]});
        if (wr_pixel_valid && wr_pixel_ready) begin
          if (q.size() == 0) begin
            chk("extra_beat", 32'd1, 32'd0);
          end else begin
            b = q.pop_front();
            chk("pix_x", {21'd0, wr_pixel_x}, {21'd0, b.x});
            chk("pix_y", {21'd0, wr_pixel_y}, {21'd0, b.y});
            chk("pix_draw", {31'd0, wr_draw}, {31'd0, b.draw});
            chk("pix_data", {24'd0, wr_pixel_data}, {24'd0, 8'(cur_g * 40 + model_cnt[cur_g])});
            chk("baseaddr", wr_baseaddr, b.base);
            chk("grant_id", {30'd0, grant_id}, cur_g);
            model_cnt[cur_g]++;
            n_beats++;
            if (b.draw) n_draws++;
            if (q.size() == 0) last_pulse = 1'b1;
          end
        end
        // Cycle after a done pulse must also stay quiet (writer returns idle).
        if (done) chk("gap_quiet_next", {27'd0, req_ready, wr_pixel_valid}, 32'd0);
        exp_done_n = wr_bvalid && (active != 0) && (q.size() == 0);
        if (req_ready != '0) begin
          chk("grant_onehot", {31'd0, $onehot(req_ready) && ((req_ready & ~req_valid) == '0)}, 32'd1);
          chk("grant_when_idle", active, 0);
          g = 0;
          for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
          if (swaps_issued != swaps_seen) begin
            front_m ^= 1;
            swaps_seen = swaps_issued;
          end
          chk("front_sel_at_grant", {31'd0, front_sel}, front_m);
          x0 = int'(req_x[g*11 +: 11]); y0 = int'(req_y[g*11 +: 11]);
          w  = int'(req_w[g*11 +: 11]); h  = int'(req_h[g*11 +: 11]);
          for (int r = 0; r <= h; r++)
            for (int c = 0; c <= w; c++) begin
              b.x    = 11'(x0 + c);
              b.y    = 11'(y0 + r);
              b.draw = src_draw[g] && (x0 + c < 800) && (y0 + r < 600);
              b.base = (front_m != 0) ? B0 : B1;
              q.push_back(b);
            end
          active = 1; cur_g = g;
          grants.push_back(g);
        end
      end
    end
  end

  // One clock of stimulus: sample at negedge, update drivers after posedge.
  task automatic tick();
    logic [N-1:0] rdy, xf;
    logic lp;
    @(negedge clk); #1;
    rdy = req_ready; xf = src_valid & src_ready; lp = last_pulse;
    @(posedge clk); #1;
    req_valid &= ~rdy;
    for (int i = 0; i < N; i++) begin
      if (xf[i]) src_cnt[i]++;
      src_data[i*8 +: 8] = 8'(i * 40 + src_cnt[i]);
    end
    wr_bvalid = 1'b0;
    if (lp) bv_delay = 3;
    else if (bv_delay > 0) begin
      bv_delay--;
      if (bv_delay == 0) wr_bvalid = 1'b1;
    end
    if (stall_en) begin
      wr_pixel_ready = 1'($urandom_range(0, 1));
      src_valid      = N'($urandom);
    end
  endtask

  task automatic send(int i, int x, int y, int w, int h, logic draw);
    req_x[i*11 +: 11] = 11'(x);
    req_y[i*11 +: 11] = 11'(y);
    req_w[i*11 +: 11] = 11'(w);
    req_h[i*11 +: 11] = 11'(h);
    src_draw[i] = draw;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_done(int target, string nm);
    int k = 0;
    while (n_done < target && k < 3000) begin tick(); k++; end
    if (n_done < target) chk({"timeout_", nm}, n_done, target);
    repeat (3) tick();
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1; swaps_issued++;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_outs1"}, {req_ready, src_ready, wr_pixel_valid, wr_draw, busy, done,
                          swap_ack, front_sel, grant_id}, 32'd0);
    chk({tag, "_base"}, wr_baseaddr, 32'd0);
    chk({tag, "_geom"}, {wr_width, wr_height, wr_pixel_data}, 32'd0);
    chk({tag, "_xy"}, {10'd0, wr_pixel_x, wr_pixel_y}, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench stuck");
  end

  initial begin : main
    int b0, d0, k, a0;
    int exp_g[4] = '{0, 1, 3, 0};
    fb_base0 = B0; fb_base1 = B1;
    reset = 1'b1; swap_req = 1'b0; req_valid = '0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0;
    src_draw = '0; src_valid = '1; wr_pixel_ready = 1'b1; wr_bvalid = 1'b0;
    for (int i = 0; i < N; i++) src_cnt[i] = 0;
    src_data = '0;
    tick(); tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();

    // Single 4x2 rectangle.
    b0 = n_beats; d0 = n_draws;
    send(0, 10, 5, 3, 1, 1'b1);
    tick();
    chk("A_width", {21'd0, wr_width}, 32'd3);
    chk("A_height", {21'd0, wr_height}, 32'd1);
    chk("A_base_back", wr_baseaddr, B1);
    chk("A_busy", {31'd0, busy}, 32'd1);
    wait_done(n_done + 1, "A");
    chk("A_beats", n_beats - b0, 8);
    chk("A_draws", n_draws - d0, 8);
    chk("A_end_x", {21'd0, wr_pixel_x}, 32'd10);
    chk("A_end_y", {21'd0, wr_pixel_y}, 32'd7);

    // Round-robin from reset, with a late re-request from 0.
    reset = 1'b1; tick(); reset = 1'b0; bv_delay = 0; wr_bvalid = 1'b0;
    grants.delete();
    a0 = n_done;
    send(0, 0, 0, 1, 0, 1'b1);
    send(1, 4, 0, 1, 0, 1'b1);
    send(3, 8, 0, 1, 0, 1'b1);
    k = 0;
    while (grants.size() < 3 && k < 500) begin tick(); k++; end
    chk("B_three_grants", grants.size(), 3);
    send(0, 12, 1, 1, 0, 1'b1);
    wait_done(a0 + 4, "B");
    chk("B_grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) chk($sformatf("B_grant%0d", i), grants[i], exp_g[i]);

    // Right and bottom edge masking.
    b0 = n_beats; d0 = n_draws;
    send(2, 798, 10, 3, 0, 1'b1);
    wait_done(n_done + 1, "C1");
    chk("C1_beats", n_beats - b0, 4);
    chk("C1_draws", n_draws - d0, 2);
    b0 = n_beats; d0 = n_draws;
    send(2, 798, 599, 3, 1, 1'b1);
    wait_done(n_done + 1, "C2");
    chk("C2_beats", n_beats - b0, 8);
    chk("C2_draws", n_draws - d0, 2);

    // Random stalls on both sides.
    b0 = n_beats;
    stall_en = 1'b1;
    send(1, 100, 200, 4, 2, 1'b1);
    wait_done(n_done + 1, "D");
    stall_en = 1'b0; wr_pixel_ready = 1'b1; src_valid = '1;
    chk("D_beats", n_beats - b0, 15);
    chk("D_end_x", {21'd0, wr_pixel_x}, 32'd100);
    chk("D_end_y", {21'd0, wr_pixel_y}, 32'd203);

    // Swap requested mid-stream; two requests collapse into one swap.
    a0 = n_ack;
    send(0, 20, 30, 7, 3, 1'b1);
    repeat (4) tick();
    pulse_swap();
    tick();
    pulse_swap();
    chk("E_base_held", wr_baseaddr, B1);
    chk("E_no_early_ack", n_ack - a0, 0);
    wait_done(n_done + 1, "E1");
    repeat (4) tick();
    chk("E_ack_once", n_ack - a0, 1);
    chk("E_front", {31'd0, front_sel}, 32'd1);
    send(0, 0, 0, 1, 0, 1'b0);
    tick();
    chk("E_base_swapped", wr_baseaddr, B0);
    wait_done(n_done + 1, "E2");

    // Reset in the middle of a stream.
    send(3, 50, 60, 9, 9, 1'b1);
    repeat (6) tick();
    chk("F_midstream_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; bv_delay = 0; wr_bvalid = 1'b0;
    tick();
    check_reset_vals("F");
    reset = 1'b0;
    tick();
    send(1, 0, 0, 0, 0, 1'b1);
    wait_done(n_done + 1, "F_recover");
    chk("F_recover_base", wr_baseaddr, B1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
